// File: rtl/y_misr_checker_pkg.sv
// Shared types and helpers for the y_misr_checker response compactor.
// Holds the FSM state encoding, the default MISR constants and the width-generic fold.
package y_misr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

   // Upper bounds for the generic fold; callers zero-extend y and truncate the result.
   localparam int MAX_Y_WIDTH   = 1024;
   localparam int MAX_SIG_WIDTH = 64;

   // Bit i of y lands in bit (i mod sig_width) of the fold, i.e. the XOR of all chunks.
   function automatic logic [MAX_SIG_WIDTH-1:0] fold_y(
      input logic [MAX_Y_WIDTH-1:0] y,
      input int                     y_width,
      input int                     sig_width
   );
      logic [MAX_SIG_WIDTH-1:0] f;
      f = '0;
      for (int i = 0; i < MAX_Y_WIDTH; i++) begin
         if (i < y_width) begin
            f[6'(i % sig_width)] = f[6'(i % sig_width)] ^ y[10'(i)];
         end
      end
      return f;
   endfunction

endpackage

// File: rtl/y_misr_checker_if.sv
// Bus between the stimulus/response harness and the MISR checker.
// The harness drives start, samples and the expected signature; the checker reports status.
interface y_misr_if #(
   parameter int Y_WIDTH   = 350,
   parameter int SIG_WIDTH = 32
);
   logic                 start;
   logic                 y_valid;
   logic [Y_WIDTH-1:0]   y;
   logic [SIG_WIDTH-1:0] exp_sig;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [SIG_WIDTH-1:0] sig;
   logic [7:0]           sample_cnt;

   modport master (
      output start, y_valid, y, exp_sig,
      input  busy, done, pass, sig, sample_cnt
   );

   modport slave (
      input  start, y_valid, y, exp_sig,
      output busy, done, pass, sig, sample_cnt
   );
endinterface

// File: rtl/y_misr_checker_misr_step.sv
// Combinational MISR step: shift left, Galois feedback through POLY, then absorb the fold.
module misr_step #(
   parameter int                   SIG_WIDTH = 32,
   parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7
) (
   input  logic [SIG_WIDTH-1:0] sig_i,
   input  logic [SIG_WIDTH-1:0] fold_i,
   output logic [SIG_WIDTH-1:0] sig_next_o
);

   for (genvar gi = 0; gi < SIG_WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
         assign sig_next_o[gi] = (POLY[gi] & sig_i[SIG_WIDTH-1]) ^ fold_i[gi];
      end else begin : g_upper
         assign sig_next_o[gi] = sig_i[gi-1] ^ (POLY[gi] & sig_i[SIG_WIDTH-1]) ^ fold_i[gi];
      end
   end

endmodule

// File: rtl/y_misr_checker.sv
// Compacts qualified y samples into a MISR and compares against exp_sig after NUM_SAMPLES.
// FSM, sample counter and compare register; the fold and step are single-cycle combinational.
module y_misr_checker
   import y_misr_pkg::*;
#(
   parameter int                   Y_WIDTH     = 350,
   parameter int                   SIG_WIDTH   = 32,
   parameter int                   NUM_SAMPLES = 21,
   parameter logic [SIG_WIDTH-1:0] POLY        = SIG_WIDTH'(DEFAULT_POLY),
   parameter logic [SIG_WIDTH-1:0] SEED        = SIG_WIDTH'(DEFAULT_SEED)
) (
   input  logic     clk,
   input  logic     rst,
   y_misr_if.slave  bus
);

   state_t               state_q;
   logic [SIG_WIDTH-1:0] sig_q;
   logic [SIG_WIDTH-1:0] sig_d;
   logic [SIG_WIDTH-1:0] fold;
   logic [7:0]           cnt_q;
   logic [7:0]           cnt_d;
   logic                 pass_q;
   logic                 busy_q;
   logic                 done_q;

   assign fold  = SIG_WIDTH'(fold_y(MAX_Y_WIDTH'(bus.y), Y_WIDTH, SIG_WIDTH));
   assign cnt_d = cnt_q + 8'd1;

   misr_step #(
      .SIG_WIDTH (SIG_WIDTH),
      .POLY      (POLY)
   ) u_step (
      .sig_i      (sig_q),
      .fold_i     (fold),
      .sig_next_o (sig_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sig_q   <= SEED;
         cnt_q   <= 8'd0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            // DONE restarts exactly like IDLE; a sample coinciding with start is dropped.
            IDLE, DONE: begin
               if (bus.start) begin
                  sig_q   <= SEED;
                  cnt_q   <= 8'd0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (bus.y_valid) begin
                  sig_q <= sig_d;
                  cnt_q <= cnt_d;
                  if (cnt_d == 8'(NUM_SAMPLES)) begin
                     state_q <= CHECK;
                  end
               end
            end
            CHECK: begin
               pass_q  <= (sig_q == bus.exp_sig);
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.sig        = sig_q;
   assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_y_misr_checker.sv
// Directed bench for y_misr_checker: four instances cover small-width corner cases and the default build.
module tb_y_misr_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   y_misr_if #(.Y_WIDTH(32),  .SIG_WIDTH(32)) ifa ();
   y_misr_if #(.Y_WIDTH(32),  .SIG_WIDTH(32)) ifb ();
   y_misr_if #(.Y_WIDTH(64),  .SIG_WIDTH(32)) ifc ();
   y_misr_if #(.Y_WIDTH(350), .SIG_WIDTH(32)) ifd ();

   y_misr_checker #(.Y_WIDTH(32), .SIG_WIDTH(32), .NUM_SAMPLES(1),
                    .POLY(32'h04C11DB7), .SEED(32'h00000000))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   y_misr_checker #(.Y_WIDTH(32), .SIG_WIDTH(32), .NUM_SAMPLES(1),
                    .POLY(32'h04C11DB7), .SEED(32'h80000000))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));
   y_misr_checker #(.Y_WIDTH(64), .SIG_WIDTH(32), .NUM_SAMPLES(1),
                    .POLY(32'h04C11DB7), .SEED(32'h00000000))
      dut_c (.clk(clk), .rst(rst), .bus(ifc));
   y_misr_checker #(.Y_WIDTH(350), .SIG_WIDTH(32), .NUM_SAMPLES(21),
                    .POLY(32'h04C11DB7), .SEED(32'hFFFFFFFF))
      dut_d (.clk(clk), .rst(rst), .bus(ifd));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: explicit chunk-by-chunk fold followed by the MISR step.
   function automatic logic [31:0] model_step(input logic [31:0] s, input logic [349:0] y);
      logic [383:0] yp;
      logic [31:0]  f;
      yp = {34'b0, y};
      f  = 32'h0;
      for (int c = 0; c < 11; c++) f = f ^ yp[c*32 +: 32];
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
   endfunction

   function automatic logic [349:0] mk_y(input int i);
      logic [383:0] t;
      for (int c = 0; c < 12; c++)
         t[c*32 +: 32] = (32'h9E3779B9 * 32'(i + 1)) ^ (32'h01234567 << c) ^ 32'(c);
      return t[349:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (ifd.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ifd.busy); end
      n_checks++; if (ifd.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", ifd.done); end
      n_checks++; if (ifd.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b expected 0", ifd.pass); end
      n_checks++; if (ifd.sig !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_sig: got %h expected ffffffff", ifd.sig); end
      n_checks++; if (ifd.sample_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", ifd.sample_cnt); end
      n_checks++; if (ifb.sig !== 32'h80000000) begin n_fail++; $display("FAIL reset_sig_b: got %h expected 80000000", ifb.sig); end
      $display("reset: done (checks so far %0d)", n_checks);
   endtask

   task automatic test_single();
      ifa.exp_sig = 32'h1;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      n_checks++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", ifa.busy); end
      ifa.y = 32'h1;
      ifa.y_valid = 1'b1;
      tick();
      ifa.y_valid = 1'b0;
      n_checks++; if (ifa.sig !== 32'h1) begin n_fail++; $display("FAIL single_sig: got %h expected 00000001", ifa.sig); end
      n_checks++; if (ifa.sample_cnt !== 8'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", ifa.sample_cnt); end
      n_checks++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL single_done_early: got %b expected 0", ifa.done); end
      tick();
      n_checks++; if (ifa.done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", ifa.done); end
      n_checks++; if (ifa.pass !== 1'b1) begin n_fail++; $display("FAIL single_pass: got %b expected 1", ifa.pass); end
      n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", ifa.busy); end
      $display("single: sig=%h done=%b pass=%b", ifa.sig, ifa.done, ifa.pass);
   endtask

   task automatic test_poly();
      ifb.exp_sig = 32'h04C11DB7;
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
      ifb.y = 32'h0;
      ifb.y_valid = 1'b1;
      tick();
      ifb.y_valid = 1'b0;
      n_checks++; if (ifb.sig !== 32'h04C11DB7) begin n_fail++; $display("FAIL poly_sig: got %h expected 04c11db7", ifb.sig); end
      tick();
      n_checks++; if (ifb.pass !== 1'b1) begin n_fail++; $display("FAIL poly_pass: got %b expected 1", ifb.pass); end
      ifb.exp_sig = 32'h0;
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
      n_checks++; if (ifb.done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b expected 0", ifb.done); end
      n_checks++; if (ifb.busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b expected 1", ifb.busy); end
      n_checks++; if (ifb.sig !== 32'h80000000) begin n_fail++; $display("FAIL restart_sig: got %h expected 80000000", ifb.sig); end
      ifb.y_valid = 1'b1;
      tick();
      ifb.y_valid = 1'b0;
      tick();
      n_checks++; if (ifb.done !== 1'b1) begin n_fail++; $display("FAIL poly_bad_done: got %b expected 1", ifb.done); end
      n_checks++; if (ifb.pass !== 1'b0) begin n_fail++; $display("FAIL poly_bad_pass: got %b expected 0", ifb.pass); end
      $display("poly: sig=%h done=%b pass=%b", ifb.sig, ifb.done, ifb.pass);
   endtask

   task automatic test_fold();
      logic [1023:0] big;
      logic [31:0]   f;
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      ifc.y = 64'h00000001_00000001;
      ifc.y_valid = 1'b1;
      tick();
      ifc.y_valid = 1'b0;
      n_checks++; if (ifc.sig !== 32'h0) begin n_fail++; $display("FAIL fold64_sig: got %h expected 00000000", ifc.sig); end
      n_checks++; if (ifc.sample_cnt !== 8'd1) begin n_fail++; $display("FAIL fold64_cnt: got %0d expected 1", ifc.sample_cnt); end
      big = '0;
      big[349] = 1'b1;
      f = 32'(y_misr_pkg::fold_y(big, 350, 32));
      n_checks++; if (f !== 32'h20000000) begin n_fail++; $display("FAIL fold349_func: got %h expected 20000000", f); end
      ifd.start = 1'b1;
      tick();
      ifd.start = 1'b0;
      ifd.y = '0;
      ifd.y[349] = 1'b1;
      ifd.y_valid = 1'b1;
      tick();
      ifd.y_valid = 1'b0;
      // ffffffff shifted = fffffffe, ^poly = fb3ee249, ^20000000 = db3ee249
      n_checks++; if (ifd.sig !== 32'hDB3EE249) begin n_fail++; $display("FAIL fold349_sig: got %h expected db3ee249", ifd.sig); end
      $display("fold: fold349=%h sig_d=%h", f, ifd.sig);
   endtask

   task automatic test_full();
      logic [31:0] s;
      logic [31:0] e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      e = 32'hFFFFFFFF;
      for (int i = 0; i < 21; i++) e = model_step(e, mk_y(i));
      ifd.exp_sig = e;
      ifd.start = 1'b1;
      tick();
      ifd.start = 1'b0;
      s = 32'hFFFFFFFF;
      for (int i = 0; i < 21; i++) begin
         ifd.y = mk_y(i);
         ifd.y_valid = 1'b1;
         tick();
         ifd.y_valid = 1'b0;
         s = model_step(s, mk_y(i));
         n_checks++; if (ifd.sig !== s) begin n_fail++; $display("FAIL full_sig[%0d]: got %h expected %h", i, ifd.sig, s); end
         n_checks++; if (ifd.sample_cnt !== 8'(i + 1)) begin n_fail++; $display("FAIL full_cnt[%0d]: got %0d expected %0d", i, ifd.sample_cnt, i + 1); end
         $display("full: sample %0d sig=%h cnt=%0d", i, ifd.sig, ifd.sample_cnt);
         if (i < 20 && (i % 4) != 0) begin
            ifd.y = ~mk_y(i);
            for (int g = 0; g < (i % 4); g++) tick();
            n_checks++; if (ifd.sig !== s) begin n_fail++; $display("FAIL full_gap_hold[%0d]: got %h expected %h", i, ifd.sig, s); end
         end
      end
      n_checks++; if (ifd.busy !== 1'b1) begin n_fail++; $display("FAIL full_check_busy: got %b expected 1", ifd.busy); end
      n_checks++; if (ifd.done !== 1'b0) begin n_fail++; $display("FAIL full_check_done: got %b expected 0", ifd.done); end
      tick();
      n_checks++; if (ifd.busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b expected 0", ifd.busy); end
      n_checks++; if (ifd.done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b expected 1", ifd.done); end
      n_checks++; if (ifd.pass !== 1'b1) begin n_fail++; $display("FAIL full_pass: got %b expected 1", ifd.pass); end
      n_checks++; if (ifd.sample_cnt !== 8'd21) begin n_fail++; $display("FAIL full_cnt_end: got %0d expected 21", ifd.sample_cnt); end
   endtask

   task automatic test_rst_mid();
      ifd.start = 1'b1;
      tick();
      ifd.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ifd.y = mk_y(i);
         ifd.y_valid = 1'b1;
         tick();
      end
      ifd.y_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (ifd.sig !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rstmid_sig: got %h expected ffffffff", ifd.sig); end
      n_checks++; if (ifd.sample_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", ifd.sample_cnt); end
      n_checks++; if (ifd.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", ifd.busy); end
      ifd.start = 1'b1;
      ifd.y_valid = 1'b1;
      ifd.y = mk_y(0);
      tick();
      ifd.start = 1'b0;
      ifd.y_valid = 1'b0;
      n_checks++; if (ifd.sample_cnt !== 8'd0) begin n_fail++; $display("FAIL startvalid_cnt: got %0d expected 0", ifd.sample_cnt); end
      n_checks++; if (ifd.sig !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL startvalid_sig: got %h expected ffffffff", ifd.sig); end
      n_checks++; if (ifd.busy !== 1'b1) begin n_fail++; $display("FAIL startvalid_busy: got %b expected 1", ifd.busy); end
      $display("rst_mid: sig=%h cnt=%0d busy=%b", ifd.sig, ifd.sample_cnt, ifd.busy);
   endtask

   task automatic test_start_in_run();
      logic [31:0] s;
      s = 32'hFFFFFFFF;
      for (int i = 0; i < 21; i++) begin
         ifd.y = mk_y(i);
         ifd.y_valid = 1'b1;
         if (i == 5) ifd.start = 1'b1;
         tick();
         ifd.start = 1'b0;
         ifd.y_valid = 1'b0;
         s = model_step(s, mk_y(i));
         if (i == 5) begin
            n_checks++; if (ifd.sample_cnt !== 8'd6) begin n_fail++; $display("FAIL runstart_cnt: got %0d expected 6", ifd.sample_cnt); end
            n_checks++; if (ifd.sig !== s) begin n_fail++; $display("FAIL runstart_sig: got %h expected %h", ifd.sig, s); end
         end
      end
      tick();
      n_checks++; if (ifd.done !== 1'b1) begin n_fail++; $display("FAIL rerun_done: got %b expected 1", ifd.done); end
      n_checks++; if (ifd.pass !== 1'b1) begin n_fail++; $display("FAIL rerun_pass: got %b expected 1", ifd.pass); end
      ifd.start = 1'b1;
      tick();
      ifd.start = 1'b0;
      n_checks++; if (ifd.done !== 1'b0) begin n_fail++; $display("FAIL donestart_done: got %b expected 0", ifd.done); end
      n_checks++; if (ifd.busy !== 1'b1) begin n_fail++; $display("FAIL donestart_busy: got %b expected 1", ifd.busy); end
      n_checks++; if (ifd.sig !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL donestart_sig: got %h expected ffffffff", ifd.sig); end
      n_checks++; if (ifd.sample_cnt !== 8'd0) begin n_fail++; $display("FAIL donestart_cnt: got %0d expected 0", ifd.sample_cnt); end
      $display("start_in_run: done=%b busy=%b sig=%h", ifd.done, ifd.busy, ifd.sig);
   endtask

   initial begin
      ifa.start = 1'b0; ifa.y_valid = 1'b0; ifa.y = '0; ifa.exp_sig = '0;
      ifb.start = 1'b0; ifb.y_valid = 1'b0; ifb.y = '0; ifb.exp_sig = '0;
      ifc.start = 1'b0; ifc.y_valid = 1'b0; ifc.y = '0; ifc.exp_sig = '0;
      ifd.start = 1'b0; ifd.y_valid = 1'b0; ifd.y = '0; ifd.exp_sig = '0;
      test_reset();
      test_single();
      test_poly();
      test_fold();
      test_full();
      test_rst_mid();
      test_start_in_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
